alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have ports, one clock domain; reset synchronous, active-high:
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  operation request, sampled only in IDLE.
REQ-005 mode  in  4  ALU mode code, latched at accepted start.
REQ-006 addr_a, addr_b, addr_d  in  8 each  operand-1, operand-2, destination data-memory addresses, latched at start.
REQ-007 wb_en  in  1  1 = write result to addr_d; 0 = flags only (compare style); latched at start.
REQ-008 dmem_addr  out  8; dmem_we  out  1; dmem_do  out  8  data-memory port, write data.
REQ-009 dmem_di  in  8  data-memory read data, valid one cycle after dmem_addr presented.
REQ-010 alu_e  out  1; alu_mode  out  4; alu_op1, alu_op2  out  8 each  drive the combinational ALU.
REQ-011 alu_out  in  8; alu_flags  in  4 = {Z,C,S,O}  ALU result and flags.
REQ-012 sreg  out  4  status register {Z,C,S,O}.
REQ-013 busy  out  1; done  out  1 (single-cycle pulse).

Function
REQ-014 FSM states IDLE, RDA, RDB, EXEC, WB; IDLE->RDA on start, then RDA->RDB->EXEC->WB->IDLE unconditionally.
REQ-015 Start accepted at edge T (state IDLE); done SHALL be high in cycle T+4 (WB); next start accepted at T+5 earliest.
REQ-016 start while not IDLE SHALL be ignored, no latching of inputs.
REQ-017 RDA: dmem_addr = addr_a, dmem_we = 0.
REQ-018 RDB: dmem_addr = addr_b; dmem_di captured into op1 register at end of cycle.
REQ-019 EXEC: dmem_di captured into op2 register; alu_e = 1; alu_mode/alu_op1/alu_op2 = latched mode/op1/op2 (alu_op2 = dmem_di, bypassed, this cycle); alu_out and alu_flags captured at end of cycle.
REQ-020 alu_e SHALL be 0 outside EXEC; alu_mode/alu_op1/alu_op2 hold last values.
REQ-021 WB: dmem_addr = addr_d, dmem_do = captured result, dmem_we = wb_en; done = 1; sreg updated at end of WB.
REQ-022 Arithmetic modes 0000, 0001, 0111, 1000, 1001, 1111: sreg <= all four captured flags.
REQ-023 All other modes (buffer, logic, shift/rotate): sreg Z,S <= captured flags; C,O retained.
REQ-024 busy = 1 in RDA, RDB, EXEC, WB; 0 in IDLE.
REQ-025 dmem_we SHALL be 0 in every state except WB; no memory write when wb_en = 0.
REQ-026 addr_d equal to addr_a or addr_b permitted; read precedes write, no hazard.

Reset
REQ-027 rst high at an edge SHALL force IDLE, sreg = 0, busy = 0, done = 0, dmem_we = 0, alu_e = 0, all address/data outputs and internal registers 0.
REQ-028 rst in any state SHALL abort the operation: no write, no sreg update, no done.
REQ-029 rst SHALL override start in the same cycle.

Structure
REQ-030 Shared package alu_pkg SHALL hold 4-bit mode constants, flag bit indices (Z=3, C=2, S=1, O=0), state enum, and an is_arith(mode) function.
REQ-031 One sub-module status_update (combinational: old sreg, new flags, mode -> next sreg) SHALL implement REQ-022/023.
REQ-032 Target 150-250 lines RTL including sub-module.

Verification (bench instantiates the team ALU as the ALU model)
REQ-033 mem[10h]=7Fh, mem[11h]=01h, mode 0000, addr_d 12h, wb_en 1, start at T -> done at T+4, mem[12h]=80h, sreg=0011b.
REQ-034 Then mem[20h]=F0h, mem[21h]=0Fh, mode 0100, addr_d 22h -> mem[22h]=00h, sreg=1001b (C,O retained).
REQ-035 mem[30h]=05h, mem[31h]=05h, mode 0001, wb_en 0 -> dmem_we never high, sreg=1100b, mem[addr_d] unchanged.
REQ-036 start pulsed at T+1 and T+2 during an operation -> ignored; exactly one done; busy high T+1..T+4.
REQ-037 rst asserted in EXEC -> next cycle IDLE, sreg=0000b, no write, no done; subsequent start completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution sequencer: mode codes, status flag
// bit positions, FSM state encoding and the arithmetic-mode classifier.
package alu_pkg;

  localparam int DW = 8;
  localparam int MW = 4;

  localparam logic [MW-1:0] MODE_ADD  = 4'b0000;
  localparam logic [MW-1:0] MODE_SUB  = 4'b0001;
  localparam logic [MW-1:0] MODE_BUFA = 4'b0010;
  localparam logic [MW-1:0] MODE_OR   = 4'b0011;
  localparam logic [MW-1:0] MODE_AND  = 4'b0100;
  localparam logic [MW-1:0] MODE_XOR  = 4'b0101;
  localparam logic [MW-1:0] MODE_SHL  = 4'b0110;
  localparam logic [MW-1:0] MODE_ADC  = 4'b0111;
  localparam logic [MW-1:0] MODE_INC  = 4'b1000;
  localparam logic [MW-1:0] MODE_DEC  = 4'b1001;
  localparam logic [MW-1:0] MODE_SHR  = 4'b1010;
  localparam logic [MW-1:0] MODE_ROL  = 4'b1011;
  localparam logic [MW-1:0] MODE_ROR  = 4'b1100;
  localparam logic [MW-1:0] MODE_NOT  = 4'b1101;
  localparam logic [MW-1:0] MODE_BUFB = 4'b1110;
  localparam logic [MW-1:0] MODE_SBC  = 4'b1111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  // Only arithmetic modes produce meaningful carry/overflow.
  function automatic logic is_arith(input logic [MW-1:0] m);
    return (m == MODE_ADD) || (m == MODE_SUB) || (m == MODE_ADC) ||
           (m == MODE_INC) || (m == MODE_DEC) || (m == MODE_SBC);
  endfunction

endpackage

// File: rtl/alu_exec_status_update.sv
// Next status register: Z and S always follow the new flags, C and O only
// for arithmetic modes so logic/shift ops keep the previous carry/overflow.
module status_update
  import alu_pkg::*;
(
  input  logic [3:0]    sreg_old,
  input  logic [3:0]    flags_new,
  input  logic [MW-1:0] mode,
  output logic [3:0]    sreg_new
);

  always_comb begin
    sreg_new         = sreg_old;
    sreg_new[FLAG_Z] = flags_new[FLAG_Z];
    sreg_new[FLAG_S] = flags_new[FLAG_S];
    if (is_arith(mode)) begin
      sreg_new[FLAG_C] = flags_new[FLAG_C];
      sreg_new[FLAG_O] = flags_new[FLAG_O];
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Memory-to-memory ALU sequencer: reads two operands, drives an external
// combinational ALU, writes the result back and updates the status register.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on accept
// RDA   | present addr_a to data memory
// RDB   | present addr_b; capture operand 1
// EXEC  | capture operand 2 (bypassed to ALU); capture result and flags
// WB    | write result if enabled; update sreg; pulse done
module alu_exec
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] mode,
  input  logic [DW-1:0] addr_a,
  input  logic [DW-1:0] addr_b,
  input  logic [DW-1:0] addr_d,
  input  logic          wb_en,
  output logic [DW-1:0] dmem_addr,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_do,
  input  logic [DW-1:0] dmem_di,
  output logic          alu_e,
  output logic [MW-1:0] alu_mode,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  input  logic [DW-1:0] alu_out,
  input  logic [3:0]    alu_flags,
  output logic [3:0]    sreg,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [MW-1:0] mode_q, mode_d;
  logic [DW-1:0] addr_a_q, addr_a_d;
  logic [DW-1:0] addr_b_q, addr_b_d;
  logic [DW-1:0] addr_d_q, addr_d_d;
  logic          wb_en_q, wb_en_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic [DW-1:0] res_q, res_d;
  logic [3:0]    flags_q, flags_d;
  logic [3:0]    sreg_q, sreg_d;
  logic [MW-1:0] alu_mode_q, alu_mode_d;
  logic [DW-1:0] alu_op1_q, alu_op1_d;
  logic [3:0]    sreg_upd;

  status_update u_status_update (
    .sreg_old  (sreg_q),
    .flags_new (flags_q),
    .mode      (mode_q),
    .sreg_new  (sreg_upd)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_d_d   = addr_d_q;
    wb_en_d    = wb_en_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    res_d      = res_q;
    flags_d    = flags_q;
    sreg_d     = sreg_q;
    alu_mode_d = alu_mode_q;
    alu_op1_d  = alu_op1_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RDA;
          mode_d   = mode;
          addr_a_d = addr_a;
          addr_b_d = addr_b;
          addr_d_d = addr_d;
          wb_en_d  = wb_en;
        end
      end
      S_RDA: state_d = S_RDB;
      S_RDB: begin
        op1_d   = dmem_di;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // op2_q doubles as the held alu_op2 value once EXEC ends.
        op2_d      = dmem_di;
        res_d      = alu_out;
        flags_d    = alu_flags;
        alu_mode_d = mode_q;
        alu_op1_d  = op1_q;
        state_d    = S_WB;
      end
      S_WB: begin
        sreg_d  = sreg_upd;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_addr = '0;
    unique case (state_q)
      S_RDA:   dmem_addr = addr_a_q;
      S_RDB:   dmem_addr = addr_b_q;
      S_WB:    dmem_addr = addr_d_q;
      default: dmem_addr = '0;
    endcase
  end

  assign alu_e    = (state_q == S_EXEC);
  assign alu_mode = alu_e ? mode_q  : alu_mode_q;
  assign alu_op1  = alu_e ? op1_q   : alu_op1_q;
  assign alu_op2  = alu_e ? dmem_di : op2_q;
  assign dmem_we  = (state_q == S_WB) && wb_en_q;
  assign dmem_do  = res_q;
  assign done     = (state_q == S_WB);
  assign busy     = (state_q != S_IDLE);
  assign sreg     = sreg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_d_q   <= '0;
      wb_en_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      sreg_q     <= '0;
      alu_mode_q <= '0;
      alu_op1_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_d_q   <= addr_d_d;
      wb_en_q    <= wb_en_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      sreg_q     <= sreg_d;
      alu_mode_q <= alu_mode_d;
      alu_op1_q  <= alu_op1_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a registered-read data memory and a small
// behavioural ALU (add/sub/and/or) standing in for the team ALU.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst, start, wb_en;
  logic [3:0] mode;
  logic [7:0] addr_a, addr_b, addr_d;
  logic [7:0] dmem_addr, dmem_do, dmem_di;
  logic       dmem_we;
  logic       alu_e;
  logic [3:0] alu_mode;
  logic [7:0] alu_op1, alu_op2, alu_out;
  logic [3:0] alu_flags, sreg;
  logic       busy, done;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr, tb_data;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int we0, dn0, cyc;

  alu_exec dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .wb_en(wb_en),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_do(dmem_do), .dmem_di(dmem_di),
    .alu_e(alu_e), .alu_mode(alu_mode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .sreg(sreg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_do;
    else if (tb_we) mem[tb_addr] <= tb_data;
    dmem_di <= mem[dmem_addr];
  end

  always_comb begin
    logic [8:0] s9;
    logic c, o;
    s9 = '0;
    c  = 1'b0;
    o  = 1'b0;
    alu_out = alu_op1;
    case (alu_mode)
      4'b0000: begin
        s9 = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_out = s9[7:0];
        c = s9[8];
        o = (alu_op1[7] == alu_op2[7]) && (s9[7] != alu_op1[7]);
      end
      4'b0001: begin
        s9 = {1'b0, alu_op1} + {1'b0, ~alu_op2} + 9'd1;
        alu_out = s9[7:0];
        c = s9[8];
        o = (alu_op1[7] != alu_op2[7]) && (s9[7] != alu_op1[7]);
      end
      4'b0011: alu_out = alu_op1 | alu_op2;
      4'b0100: alu_out = alu_op1 & alu_op2;
      default: alu_out = alu_op1;
    endcase
    alu_flags = {(alu_out == 8'h00), c, alu_out[7], o};
  end

  always @(negedge clk) begin
    if (dmem_we) we_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Drives start for one edge; returns at the negedge of cycle T+1 (RDA).
  task automatic start_op(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic w);
    start = 1'b1; mode = m; addr_a = a; addr_b = b; addr_d = d; wb_en = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the RDA negedge, step until done; cycle index relative to T.
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 12) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; addr_a = '0; addr_b = '0; addr_d = '0;
    wb_en = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sreg", sreg, 4'h0);
    chk("rst_we", dmem_we, 0);
    chk("rst_alu_e", alu_e, 0);
    chk("rst_addr", dmem_addr, 8'h00);
    chk("rst_do", dmem_do, 8'h00);
    rst = 1'b0;

    poke(8'h10, 8'h7F); poke(8'h11, 8'h01); poke(8'h12, 8'hEE);
    poke(8'h20, 8'hF0); poke(8'h21, 8'h0F); poke(8'h22, 8'h33);
    poke(8'h30, 8'h05); poke(8'h31, 8'h05); poke(8'h32, 8'h77);
    poke(8'h60, 8'h10); poke(8'h61, 8'h20); poke(8'h62, 8'h55);
    poke(8'h40, 8'hFF); poke(8'h41, 8'h01); poke(8'h42, 8'h99);
    poke(8'h50, 8'hAA);

    // ADD 7F+01, cycle-by-cycle
    we0 = we_cnt; dn0 = done_cnt;
    start_op(4'b0000, 8'h10, 8'h11, 8'h12, 1'b1);
    chk("add_rda_busy", busy, 1);
    chk("add_rda_addr", dmem_addr, 8'h10);
    chk("add_rda_alu_e", alu_e, 0);
    chk("add_rda_we", dmem_we, 0);
    @(negedge clk);
    chk("add_rdb_addr", dmem_addr, 8'h11);
    chk("add_rdb_done", done, 0);
    @(negedge clk);
    chk("add_exec_alu_e", alu_e, 1);
    chk("add_exec_op1", alu_op1, 8'h7F);
    chk("add_exec_op2", alu_op2, 8'h01);
    chk("add_exec_mode", alu_mode, 4'b0000);
    chk("add_exec_we", dmem_we, 0);
    @(negedge clk);
    chk("add_wb_done", done, 1);
    chk("add_wb_we", dmem_we, 1);
    chk("add_wb_addr", dmem_addr, 8'h12);
    chk("add_wb_do", dmem_do, 8'h80);
    @(negedge clk);
    chk("add_idle_busy", busy, 0);
    chk("add_idle_done", done, 0);
    chk("add_mem", mem[8'h12], 8'h80);
    chk("add_sreg", sreg, 4'b0011);
    chk("add_hold_alu_e", alu_e, 0);
    chk("add_hold_op1", alu_op1, 8'h7F);
    chk("add_hold_op2", alu_op2, 8'h01);
    chk("add_we_count", we_cnt - we0, 1);
    chk("add_done_count", done_cnt - dn0, 1);

    // AND: logic mode keeps C,O
    start_op(4'b0100, 8'h20, 8'h21, 8'h22, 1'b1);
    wait_done(cyc);
    chk("and_latency", cyc, 4);
    @(negedge clk);
    chk("and_mem", mem[8'h22], 8'h00);
    chk("and_sreg", sreg, 4'b1001);

    // SUB compare, no write-back
    we0 = we_cnt;
    start_op(4'b0001, 8'h30, 8'h31, 8'h32, 1'b0);
    wait_done(cyc);
    chk("sub_latency", cyc, 4);
    @(negedge clk);
    chk("sub_sreg", sreg, 4'b1100);
    chk("sub_mem", mem[8'h32], 8'h77);
    chk("sub_we_count", we_cnt - we0, 0);

    // Reset while in EXEC aborts
    we0 = we_cnt; dn0 = done_cnt;
    start_op(4'b0000, 8'h60, 8'h61, 8'h62, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rstx_in_exec", alu_e, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstx_busy", busy, 0);
    chk("rstx_done", done, 0);
    chk("rstx_sreg", sreg, 4'b0000);
    chk("rstx_alu_e", alu_e, 0);
    chk("rstx_addr", dmem_addr, 8'h00);
    @(negedge clk);
    chk("rstx_mem", mem[8'h62], 8'h55);
    chk("rstx_we_count", we_cnt - we0, 0);
    chk("rstx_done_count", done_cnt - dn0, 0);

    // Start pulses during an operation are ignored
    dn0 = done_cnt;
    start_op(4'b0000, 8'h40, 8'h41, 8'h42, 1'b1);
    start = 1'b1; mode = 4'b0001; addr_a = 8'h50; addr_d = 8'h50;
    chk("ign_busy_t1", busy, 1);
    @(negedge clk);
    chk("ign_busy_t2", busy, 1);
    start = 1'b0;
    @(negedge clk);
    chk("ign_busy_t3", busy, 1);
    @(negedge clk);
    chk("ign_busy_t4", busy, 1);
    chk("ign_done_t4", done, 1);
    chk("ign_addr_t4", dmem_addr, 8'h42);
    @(negedge clk);
    chk("ign_busy_t5", busy, 0);
    @(negedge clk);
    chk("ign_busy_t6", busy, 0);
    chk("ign_done_count", done_cnt - dn0, 1);
    chk("ign_mem42", mem[8'h42], 8'h00);
    chk("ign_mem50", mem[8'h50], 8'hAA);
    chk("ign_sreg", sreg, 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
